// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle unsigned add/subtract unit.
//   Processes one CHUNK-bit slice of the operands per RUN cycle, keeping the
//   ripple carry in a register between cycles. Operands arrive through a
//   valid/ready handshake and the (WIDTH+1)-bit result leaves through another.
//   R[WIDTH-1:0] is the sum/difference mod 2^WIDTH; R[WIDTH] is the carry
//   (add) or the borrow (subtract).
// Optional feature: define CHUNKED_ADDSUB_OVF_EN to add the OVF output, the
//   two's-complement overflow of the final slice, registered alongside R[WIDTH].
module chunked_addsub #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             SUB,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH:0]   R
`ifdef CHUNKED_ADDSUB_OVF_EN
   ,
   output logic             OVF
`endif
);

   // Number of slices and width of the slice index (at least one bit).
   localparam int N     = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   // Reject configurations where the operand does not split into whole slices.
   generate
      if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
         $error("chunked_addsub: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;       // B already inverted for subtraction
   logic               sub_q, sub_d;
   logic               carry_q, carry_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH:0]     r_q, r_d;
`ifdef CHUNKED_ADDSUB_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   logic [CHUNK-1:0]   a_slice;
   logic [CHUNK-1:0]   b_slice;
   logic [CHUNK:0]     sum_w;          // {carry out, slice sum}
   logic               last_slice;
   logic               accept;

   assign IN_READY  = (state_q == S_IDLE) && !RESET;
   assign OUT_VALID = (state_q == S_DONE);
   assign R         = r_q;
   assign accept    = IN_VALID && IN_READY;
`ifdef CHUNKED_ADDSUB_OVF_EN
   assign OVF       = ovf_q;
`endif

   // Select the current operand slices and add them with the held carry.
   always_comb begin
      // NOTE: every variable written here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      a_slice    = '0;
      b_slice    = '0;
      for (int i = 0; i < N; i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_slice = a_q[i*CHUNK +: CHUNK];
            b_slice = b_q[i*CHUNK +: CHUNK];
         end
      end
      sum_w      = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
      last_slice = (idx_q == IDX_W'(N - 1));
   end

   // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      r_d     = r_q;
`ifdef CHUNKED_ADDSUB_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               // Subtraction is A + ~B + 1: invert B here, seed carry with 1.
               a_d     = A;
               b_d     = B ^ {WIDTH{SUB}};
               sub_d   = SUB;
               carry_d = SUB;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            for (int i = 0; i < N; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  r_d[i*CHUNK +: CHUNK] = sum_w[CHUNK-1:0];
               end
            end
            carry_d = sum_w[CHUNK];
            idx_d   = idx_q + IDX_W'(1);
            if (last_slice) begin
               // A final carry of 1 during subtraction means no borrow.
               r_d[WIDTH] = sub_q ? ~sum_w[CHUNK] : sum_w[CHUNK];
`ifdef CHUNKED_ADDSUB_OVF_EN
               // Carry into the MSB is recovered from the MSB sum bit.
               ovf_d = sum_w[CHUNK-1] ^ a_slice[CHUNK-1] ^ b_slice[CHUNK-1]
                     ^ sum_w[CHUNK];
`endif
               idx_d   = '0;
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            if (OUT_READY) begin
`ifdef CHUNKED_ADDSUB_OVF_EN
               ovf_d = 1'b0;
`endif
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; RESET discards any operation in flight.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         // NOTE: operand registers are reset too; they are few flops and
         // keeping them deterministic costs nothing observable.
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         r_q     <= '0;
`ifdef CHUNKED_ADDSUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // values from before this edge, independent of statement order.
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         r_q     <= r_d;
`ifdef CHUNKED_ADDSUB_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

endmodule

// File: tb/tb_chunked_addsub.sv
// Testbench for chunked_addsub: two instances (WIDTH=8/CHUNK=2 and
// WIDTH=8/CHUNK=8) share the stimulus; a select picks the one under test.
// Expected results are pushed to a scoreboard queue when an operation is
// driven and popped when the selected instance presents its result.
// OVF checks are compiled in when CHUNKED_ADDSUB_OVF_EN is defined.
module tb_chunked_addsub;

   typedef struct packed {
      logic [8:0] r;
      logic       ovf;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       IN_VALID;
   logic       OUT_READY;
   logic       SUB;
   logic [7:0] A;
   logic [7:0] B;
   logic       sel;
   logic       keep_ready;

   logic       in_ready0, in_ready1, out_valid0, out_valid1;
   logic [8:0] r0, r1;
   logic       ovf0, ovf1;
   logic       in_ready, out_valid, ovf;
   logic [8:0] r;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   lat = 4;
   exp_t sb[$];

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   chunked_addsub #(.WIDTH(8), .CHUNK(2)) dut0 (
      .CLK      (CLK),
      .RESET    (RESET),
      .IN_VALID (IN_VALID & ~sel),
      .IN_READY (in_ready0),
      .A        (A),
      .B        (B),
      .SUB      (SUB),
      .OUT_VALID(out_valid0),
      .OUT_READY(OUT_READY & ~sel),
      .R        (r0)
`ifdef CHUNKED_ADDSUB_OVF_EN
      ,
      .OVF      (ovf0)
`endif
   );

   chunked_addsub #(.WIDTH(8), .CHUNK(8)) dut1 (
      .CLK      (CLK),
      .RESET    (RESET),
      .IN_VALID (IN_VALID & sel),
      .IN_READY (in_ready1),
      .A        (A),
      .B        (B),
      .SUB      (SUB),
      .OUT_VALID(out_valid1),
      .OUT_READY(OUT_READY & sel),
      .R        (r1)
`ifdef CHUNKED_ADDSUB_OVF_EN
      ,
      .OVF      (ovf1)
`endif
   );

`ifndef CHUNKED_ADDSUB_OVF_EN
   assign ovf0 = 1'b0;
   assign ovf1 = 1'b0;
`endif

   assign in_ready  = sel ? in_ready1  : in_ready0;
   assign out_valid = sel ? out_valid1 : out_valid0;
   assign r         = sel ? r1         : r0;
   assign ovf       = sel ? ovf1       : ovf0;

   // Reference model: 9-bit result and signed overflow of an 8-bit op.
   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
      exp_t       e;
      logic [8:0] t;
      logic [7:0] d;
      if (!s) begin
         t     = {1'b0, a} + {1'b0, b};
         e.r   = t;
         e.ovf = (a[7] == b[7]) && (t[7] != a[7]);
      end else begin
         d     = a - b;
         e.r   = {(a < b), d};
         e.ovf = (a[7] != b[7]) && (d[7] != a[7]);
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait for IN_READY, present one operation, and push its expected result.
   // busy_valid keeps IN_VALID asserted with junk operands after the accept.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic busy_valid);
      int t = 0;
      @(negedge CLK);
      while (!in_ready && t < 50) begin
         @(negedge CLK);
         t++;
      end
      check("in_ready_wait", {15'd0, in_ready}, 16'd1);
      A        = a;
      B        = b;
      SUB      = s;
      IN_VALID = 1'b1;
      sb.push_back(model(a, b, s));
      @(posedge CLK);
      #1;
      acc_cyc  = cyc;
      IN_VALID = busy_valid;
      A        = 8'($urandom);
      B        = 8'($urandom);
      SUB      = ~s;
   endtask

   // Wait for OUT_VALID, check latency and result, optionally hold OUT_READY
   // low for 'hold' cycles, then release the result.
   task automatic collect(input int hold);
      exp_t e;
      int   t = 0;
      e = sb.pop_front();
      @(negedge CLK);
      while (!out_valid && t < 60) begin
         @(negedge CLK);
         t++;
      end
      check("latency", 16'(cyc - acc_cyc), 16'(lat));
      check("r", {7'd0, r}, {7'd0, e.r});
`ifdef CHUNKED_ADDSUB_OVF_EN
      check("ovf", {15'd0, ovf}, {15'd0, e.ovf});
`endif
      for (int i = 0; i < hold; i++) begin
         IN_VALID = (i % 2 == 0);
         A        = 8'($urandom);
         B        = 8'($urandom);
         @(negedge CLK);
         check("hold_valid", {15'd0, out_valid}, 16'd1);
         check("hold_r", {7'd0, r}, {7'd0, e.r});
         check("hold_in_ready", {15'd0, in_ready}, 16'd0);
      end
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      @(posedge CLK);
      #1;
      if (!keep_ready) OUT_READY = 1'b0;
      @(negedge CLK);
      check("valid_drop", {15'd0, out_valid}, 16'd0);
      check("idle_ready", {15'd0, in_ready}, 16'd1);
`ifdef CHUNKED_ADDSUB_OVF_EN
      check("ovf_clear", {15'd0, ovf}, 16'd0);
`endif
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sel        = 1'b0;
      keep_ready = 1'b0;
      RESET      = 1'b1;
      IN_VALID   = 1'b0;
      OUT_READY  = 1'b0;
      SUB        = 1'b0;
      A          = '0;
      B          = '0;

      // Reset values
      repeat (2) @(negedge CLK);
      check("rst_valid0", {15'd0, out_valid0}, 16'd0);
      check("rst_r0", {7'd0, r0}, 16'd0);
      check("rst_valid1", {15'd0, out_valid1}, 16'd0);
      check("rst_r1", {7'd0, r1}, 16'd0);
      RESET = 1'b0;
      @(negedge CLK);
      check("rst_ready", {15'd0, in_ready}, 16'd1);

      // Directed operations on the 4-slice instance
      do_op(8'd200, 8'd100, 1'b0, 1'b0); collect(0);   // 9'h12C
      do_op(8'd5,   8'd7,   1'b1, 1'b1); collect(0);   // 9'h1FE
      do_op(8'd7,   8'd5,   1'b1, 1'b0); collect(0);   // 9'h002
      do_op(8'd255, 8'd1,   1'b0, 1'b0); collect(0);   // 9'h100
      do_op(8'd127, 8'd1,   1'b0, 1'b0); collect(0);   // 9'h080, overflow
      do_op(8'd128, 8'd1,   1'b1, 1'b0); collect(0);   // overflow
      do_op(8'd1,   8'd1,   1'b0, 1'b0); collect(0);   // no overflow
      do_op(8'd0,   8'd0,   1'b1, 1'b0); collect(0);   // 0 - 0
      do_op(8'd0,   8'd255, 1'b1, 1'b0); collect(0);   // max borrow
      for (int i = 0; i < 6; i++) begin
         do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
         collect(0);
      end

      // Consumer stalls for 10 cycles while IN_VALID pulses
      do_op(8'hA5, 8'h3C, 1'b1, 1'b1); collect(10);

      // OUT_READY held high throughout, including outside DONE
      keep_ready = 1'b1;
      OUT_READY  = 1'b1;
      do_op(8'h80, 8'h80, 1'b0, 1'b0); collect(0);
      keep_ready = 1'b0;
      OUT_READY  = 1'b0;

      // Reset two cycles after accept discards the operation
      do_op(8'hFF, 8'h00, 1'b0, 1'b0);
      void'(sb.pop_back());
      @(posedge CLK);
      @(posedge CLK);
      #1;
      check("partial_r", {12'd0, r[3:0]}, 16'hF);
      RESET = 1'b1;
      #1;
      check("midrst_valid", {15'd0, out_valid}, 16'd0);
      check("midrst_r", {7'd0, r}, 16'd0);
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         check("postrst_valid", {15'd0, out_valid}, 16'd0);
      end
      do_op(8'd3, 8'd4, 1'b0, 1'b0); collect(0);      // 9'h007

      // Single-slice instance: one RUN cycle
      sel = 1'b1;
      lat = 1;
      do_op(8'd255, 8'd1,   1'b0, 1'b0); collect(0);
      do_op(8'd200, 8'd100, 1'b0, 1'b1); collect(0);
      do_op(8'd5,   8'd7,   1'b1, 1'b0); collect(3);
      do_op(8'd127, 8'd1,   1'b0, 1'b0); collect(0);

      check("sb_empty", 16'(sb.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
